// File: rtl/associative_buffer_drainer.sv
// Read-side sweeper for the associative buffer: visits each address once per start,
// offers every valid entry on a valid/ready stream and clears it on acceptance.
module associative_buffer_drainer #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 1
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             start,
  output logic [SIZE-1:0]  buf_address,
  input  logic [WIDTH-1:0] buf_data,
  input  logic             buf_valid,
  output logic             buf_clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [SIZE:0]    count
);

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT, DONE} state_t;

  localparam logic [SIZE-1:0] LAST_ADDR = '1;

  state_t          state, state_nx;
  logic [SIZE-1:0] addr;
  logic            at_last;
  logic            accept;

  assign at_last     = (addr == LAST_ADDR);
  assign accept      = (state == PRESENT) && out_ready;
  assign buf_address = addr;

  always_ff @(posedge clk) begin
    if (sync_reset) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN: begin
        if (buf_valid)    state_nx = PRESENT;
        else if (at_last) state_nx = DONE;
      end
      PRESENT: begin
        if (out_ready) state_nx = at_last ? DONE : SCAN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address, captured entry and drain count; the sweep never wraps past the last address.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      addr     <= '0;
      out_data <= '0;
      count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr  <= '0;
            count <= '0;
          end
        end
        SCAN: begin
          if (buf_valid)     out_data <= buf_data;
          else if (!at_last) addr     <= addr + 1'b1;
        end
        PRESENT: begin
          if (out_ready) begin
            count <= count + 1'b1;
            if (!at_last) addr <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == PRESENT);
    busy      = (state == SCAN) || (state == PRESENT);
    done      = (state == DONE);
    // Reset wins over an acceptance so no entry is lost in the buffer.
    buf_clear = accept && !sync_reset;
  end

endmodule
